// File: rtl/math_sub_fab_pkg.sv
// Shared math utility helpers for the fabric adder/subtractor family.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
// Contents: slice_width()       - bits per pipeline slice for a WIDTH/LATENCY pair
//           width_is_multiple() - legality check, WIDTH must split evenly into slices
package math_sub_fab_pkg;

  // Each pipeline stage owns one slice, so there are LATENCY+1 slices.
  function automatic int slice_width(input int width, input int latency);
    return width / (latency + 1);
  endfunction

  function automatic bit width_is_multiple(input int width, input int latency);
    return (width % (latency + 1)) == 0;
  endfunction

endpackage

// File: rtl/shift_reg.sv
// Generic enabled delay line, DEPTH stages of WIDTH bits; DEPTH=0 is a plain wire.
// Latency: DEPTH enabled clk cycles.
// Backpressure: none; ena low freezes every stage.
// Ports: clk, ena (advance), din (WIDTH), dout (WIDTH, din delayed DEPTH enabled cycles).
// Data stages carry no reset; consumers qualify them with their own valid.
module shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk ^ ena;
    assign dout        = din;
  end else begin : g_regs
    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk) begin
      if (ena) begin
        stg[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stg[i] <= stg[i-1];
        end
      end
    end

    assign dout = stg[DEPTH-1];
  end

endmodule

// File: rtl/math_sub_fab.sv
// Signed fabric subtractor dout = dina - dinb (mod 2^WIDTH), sliced carry chain, plus overflow flag.
// Latency: LATENCY enabled clk cycles (0 = combinational); one op per enabled cycle.
// Backpressure: none; ena low holds all carries, valids and data stages.
// Ports: clk, rst_n (sync, active-low), ena, vld_in, dina/dinb (WIDTH, signed),
//        vld_out, dout (WIDTH, signed, top slice unregistered), ovf (signed overflow, 0 when !vld_out).
module math_sub_fab
  import math_sub_fab_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] dina,
  input  logic [WIDTH-1:0] dinb,
  output logic             vld_out,
  output logic [WIDTH-1:0] dout,
  output logic             ovf
);

  localparam int NSL = LATENCY + 1;
  localparam int SW  = slice_width(WIDTH, LATENCY);
  localparam int SW1 = SW + 1;

  if (!width_is_multiple(WIDTH, LATENCY)) begin : g_bad_width
    $error("math_sub_fab: WIDTH must be a multiple of LATENCY+1");
  end

  // ci[n] is the carry into slice n. Subtraction is a + ~b + 1, so the
  // chain starts with carry 1 and carry-out means "no borrow".
  logic ci [NSL];
  logic sa;
  logic sb;

  assign ci[0] = 1'b1;

  for (genvar n = 0; n < NSL; n++) begin : g_slc
    logic [SW-1:0] a_d;
    logic [SW-1:0] b_d;

    // Slice n works on its word n cycles after the bottom slice, in step
    // with the registered carry arriving from below.
    shift_reg #(.WIDTH(SW), .DEPTH(n)) u_skew_a (
      .clk  (clk),
      .ena  (ena),
      .din  (dina[n*SW +: SW]),
      .dout (a_d)
    );

    shift_reg #(.WIDTH(SW), .DEPTH(n)) u_skew_b (
      .clk  (clk),
      .ena  (ena),
      .din  (dinb[n*SW +: SW]),
      .dout (b_d)
    );

    if (n < LATENCY) begin : g_low
      logic [SW-1:0] sum;
      logic          co;
      logic          cq;

      // Zero-extend ~b explicitly: inverting after context widening would
      // put a 1 in the carry position.
      assign {co, sum} = {1'b0, a_d} + {1'b0, ~b_d} + SW1'(ci[n]);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cq <= 1'b0;
        end else if (ena) begin
          cq <= co;
        end
      end

      assign ci[n+1] = cq;

      // Hold this slice's result until the top slice finishes the same word.
      shift_reg #(.WIDTH(SW), .DEPTH(LATENCY - n)) u_deskew (
        .clk  (clk),
        .ena  (ena),
        .din  (sum),
        .dout (dout[n*SW +: SW])
      );
    end else begin : g_top
      assign dout[n*SW +: SW] = a_d + ~b_d + SW'(ci[n]);
      assign sa               = a_d[SW-1];
      assign sb               = b_d[SW-1];
    end
  end

  if (LATENCY == 0) begin : g_vld_comb
    assign vld_out = vld_in;
  end else begin : g_vld_pipe
    logic [LATENCY-1:0] vld_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= '0;
      end else if (ena) begin
        vld_q <= LATENCY'({vld_q, vld_in});
      end
    end

    assign vld_out = vld_q[LATENCY-1];
  end

  // Overflow only when operand signs differ and the result sign departs from the minuend.
  assign ovf = vld_out && (sa != sb) && (dout[WIDTH-1] != sa);

endmodule

// File: tb/tb_math_sub_fab.sv
module tb_math_sub_fab;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        ena_a, vld_a, vo_a, ovf_a;
  logic [15:0] dina_a, dinb_a, dout_a;
  logic        ena_b, vld_b, vo_b, ovf_b;
  logic [31:0] dina_b, dinb_b, dout_b;
  logic        ena_c, vld_c, vo_c, ovf_c;
  logic [7:0]  dina_c, dinb_c, dout_c;

  math_sub_fab #(.WIDTH(16), .LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .vld_in(vld_a), .dina(dina_a), .dinb(dinb_a),
    .vld_out(vo_a), .dout(dout_a), .ovf(ovf_a));

  math_sub_fab #(.WIDTH(32), .LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .vld_in(vld_b), .dina(dina_b), .dinb(dinb_b),
    .vld_out(vo_b), .dout(dout_b), .ovf(ovf_b));

  math_sub_fab #(.WIDTH(8), .LATENCY(0)) u_c (
    .clk(clk), .rst_n(rst_n), .ena(ena_c), .vld_in(vld_c), .dina(dina_c), .dinb(dinb_c),
    .vld_out(vo_c), .dout(dout_c), .ovf(ovf_c));

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard per instance: expected difference, overflow, enabled-edge count at issue.
  logic [31:0] q_d [3][$];
  logic        q_o [3][$];
  int          q_t [3][$];
  logic [31:0] last_d [3];
  logic        last_o [3];

  int   ecnt_a = 0, ecnt_b = 0;
  logic en_a_q = 1'b0, en_b_q = 1'b0, rst_q = 1'b0;

  always @(posedge clk) begin
    rst_q  <= rst_n;
    en_a_q <= ena_a;
    en_b_q <= ena_b;
    if (ena_a) ecnt_a <= ecnt_a + 1;
    if (ena_b) ecnt_b <= ecnt_b + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact signed difference in 64 bits, then range test and wrap.
  function automatic logic [32:0] ref_sub(input int w, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, df, lim;
    logic [63:0] m;
    logic ov;
    lim = longint'(1) << (w - 1);
    sa  = longint'(a);
    sb  = longint'(b);
    if (a[w-1]) sa = sa - 2 * lim;
    if (b[w-1]) sb = sb - 2 * lim;
    df = sa - sb;
    ov = (df >= lim) || (df < -lim);
    m  = (64'd1 << w) - 64'd1;
    return {ov, df[31:0] & m[31:0]};
  endfunction

  task automatic mon_step(input int k, input string nm, input logic vo, input logic [31:0] d,
                          input logic o, input logic rst_ok, input logic en_q,
                          input int ecnt, input int lat);
    logic [31:0] ed;
    logic        eo;
    int          t;
    if (vo !== 1'b1) return;
    if (!rst_ok) begin
      chk({nm, "_vld_after_rst"}, {31'b0, vo}, 32'd0);
      return;
    end
    if (!en_q) begin
      chk({nm, "_hold_dout"}, d, last_d[k]);
      chk({nm, "_hold_ovf"}, {31'b0, o}, {31'b0, last_o[k]});
      return;
    end
    if (q_d[k].size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_unexpected: vld_out=1 with dout %h, expected no word", nm, d);
      return;
    end
    ed = q_d[k].pop_front();
    eo = q_o[k].pop_front();
    t  = q_t[k].pop_front();
    chk({nm, "_dout"}, d, ed);
    chk({nm, "_ovf"}, {31'b0, o}, {31'b0, eo});
    if (lat > 0) chk({nm, "_latency"}, ecnt - t, lat);
    last_d[k] = ed;
    last_o[k] = eo;
  endtask

  always @(negedge clk) mon_step(0, "a", vo_a, {16'b0, dout_a}, ovf_a, rst_q, en_a_q, ecnt_a, 1);
  always @(negedge clk) mon_step(1, "b", vo_b, dout_b, ovf_b, rst_q, en_b_q, ecnt_b, 3);
  always @(negedge clk) mon_step(2, "c", vo_c, {24'b0, dout_c}, ovf_c, 1'b1, 1'b1, 0, 0);

  task automatic send_a(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ed, input logic eo);
    ena_a = 1'b1; vld_a = 1'b1; dina_a = a; dinb_a = b;
    q_d[0].push_back({16'b0, ed}); q_o[0].push_back(eo); q_t[0].push_back(ecnt_a);
    @(posedge clk); #1;
    vld_a = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                        input logic eo, input bit push);
    ena_b = 1'b1; vld_b = 1'b1; dina_b = a; dinb_b = b;
    if (push) begin
      q_d[1].push_back(ed); q_o[1].push_back(eo); q_t[1].push_back(ecnt_b);
    end
    @(posedge clk); #1;
    vld_b = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed, input logic eo);
    ena_c = 1'b1; vld_c = 1'b1; dina_c = a; dinb_c = b;
    q_d[2].push_back({24'b0, ed}); q_o[2].push_back(eo); q_t[2].push_back(0);
    @(posedge clk); #1;
    vld_c = 1'b0;
  endtask

  initial begin
    logic [32:0] r;
    logic [15:0] ra, rb;

    rst_n = 1'b0;
    ena_a = 1'b0; vld_a = 1'b0; dina_a = '0; dinb_a = '0;
    ena_b = 1'b0; vld_b = 1'b0; dina_b = '0; dinb_b = '0;
    ena_c = 1'b0; vld_c = 1'b0; dina_c = '0; dinb_c = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld_a", {31'b0, vo_a}, 32'd0);
    chk("rst_ovf_a", {31'b0, ovf_a}, 32'd0);
    chk("rst_vld_b", {31'b0, vo_b}, 32'd0);
    chk("rst_ovf_b", {31'b0, ovf_b}, 32'd0);
    rst_n = 1'b1;

    // WIDTH=16, LATENCY=1: basic, cross-slice borrow, overflow, x-x.
    send_a(16'h0005, 16'h0003, 16'h0002, 1'b0);
    send_a(16'h0100, 16'h0001, 16'h00FF, 1'b0);
    send_a(16'h0000, 16'h0001, 16'hFFFF, 1'b0);
    send_a(16'h8000, 16'h0001, 16'h7FFF, 1'b1);
    send_a(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1);
    send_a(16'h8000, 16'h8000, 16'h0000, 1'b0);
    send_a(16'h1234, 16'h1234, 16'h0000, 1'b0);
    ena_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Stall stream: ena drops between words while junk is offered with vld_in high.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2)) begin
        ena_a = 1'b0; vld_a = 1'b1; dina_a = 16'hDEAD; dinb_a = 16'hBEEF;
        @(posedge clk); #1;
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      r  = ref_sub(16, {16'b0, ra}, {16'b0, rb});
      send_a(ra, rb, r[15:0], r[32]);
    end
    ena_a = 1'b1; vld_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // WIDTH=8, LATENCY=0: combinational, vld_out follows vld_in.
    send_c(8'h80, 8'h01, 8'h7F, 1'b1);
    send_c(8'h05, 8'h03, 8'h02, 1'b0);
    send_c(8'h00, 8'h01, 8'hFF, 1'b0);
    send_c(8'h7F, 8'hFF, 8'h80, 1'b1);

    // WIDTH=32, LATENCY=3: borrow through every slice, overflow, normal.
    send_b(32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1);
    send_b(32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1);
    send_b(32'h12340000, 32'h00000001, 32'h1233FFFF, 1'b0, 1'b1);
    ena_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Reset mid-stream: two words in the pipe, a third offered on the reset edge
    // with ena low; none of them may emerge.
    send_b(32'hAAAA5555, 32'h11111111, 32'h0, 1'b0, 1'b0);
    send_b(32'h0F0F0F0F, 32'h00000010, 32'h0, 1'b0, 1'b0);
    ena_b = 1'b0; vld_b = 1'b1; dina_b = 32'h55555555; dinb_b = 32'h1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; vld_b = 1'b0;
    send_b(32'h12345678, 32'h00000079, 32'h123455FF, 1'b0, 1'b1);
    ena_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ena_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    chk("a_drained", q_d[0].size(), 32'd0);
    chk("b_drained", q_d[1].size(), 32'd0);
    chk("c_drained", q_d[2].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
